bus_responder: RTL and testbench



---
 rtl/bus_resp_pkg.sv | 29 ++
 rtl/bus_resp_regbank.sv | 32 +++
 rtl/bus_responder.sv | 120 ++++++++++++
 tb/tb_bus_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_resp_pkg.sv
// Shared types for the bus responder: FSM states, latched operation encoding
// and the wait-state limit.
package bus_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_BAD
    } op_t;

    localparam int WAIT_CYCLES_MAX = 15;

    // Only called once a strobe is known to be present.
    function automatic op_t decode_op(input logic wr, input logic rd);
        if (wr && rd)
            return OP_BAD;
        else if (wr)
            return OP_WR;
        else
            return OP_RD;
    endfunction

endpackage

// File: rtl/bus_resp_regbank.sv
// DEPTH x DATA_W register storage with one synchronous write port and one
// combinational read port; every entry clears on reset.
module bus_resp_regbank
    import bus_resp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_responder.sv
// Target side of the simple CPU bus: latches one request, waits WAIT_CYCLES,
// then completes with a one-cycle ack/err. Define BUS_RESPONDER_WPROT_EN for
// the lock register at DEPTH-1 that write-protects the lower half of the bank.
module bus_responder
    import bus_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_wr,
    output logic [DATA_W-1:0] data_rd,
    output logic              ack,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        wait_cnt;
    logic              oor;
    logic              prot;
    logic              bad;
    logic              bank_we;
    logic [DATA_W-1:0] bank_rdata;

    assign oor     = {1'b0, addr_q} >= DEPTH_A;
    assign bad     = oor || (op_q == OP_BAD) || prot;
    assign bank_we = (state == ACK) && (op_q == OP_WR) && !bad;

`ifdef BUS_RESPONDER_WPROT_EN
    localparam logic [ADDR_W:0] HALF_A = (ADDR_W+1)'(DEPTH / 2);
    localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(DEPTH - 1);

    logic lock_q;

    // Shadow of bit0 of the lock register; the bank copy serves reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock_q <= 1'b0;
        else if (bank_we && ({1'b0, addr_q} == LAST_A))
            lock_q <= data_q[0];
    end

    assign prot = lock_q && (op_q == OP_WR) && ({1'b0, addr_q} < HALF_A);
`else
    assign prot = 1'b0;
`endif

    bus_resp_regbank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_regbank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bank_we),
        .waddr (addr_q[IDX_W-1:0]),
        .wdata (data_q),
        .raddr (addr_q[IDX_W-1:0]),
        .rdata (bank_rdata)
    );

    // ACK is the execute cycle: the edge leaving it commits and raises ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_BAD;
            addr_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            data_rd  <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ce && (wr || rd)) begin
                        addr_q   <= addr;
                        data_q   <= data_wr;
                        op_q     <= decode_op(wr, rd);
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES > 0) ? WAIT : ACK;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= ACK;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ACK: begin
                    ack <= 1'b1;
                    err <= bad;
                    if (oor)
                        data_rd <= '0;
                    else if (op_q == OP_RD)
                        data_rd <= bank_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: a zero-wait full-depth unit and a three-wait
// half-depth unit driven by directed and random transactions.
module tb_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   [2];
    logic       ce      [2];
    logic       wr      [2];
    logic       rd      [2];
    logic [7:0] addr    [2];
    logic [7:0] data_wr [2];
    logic [7:0] data_rd [2];
    logic       ack     [2];
    logic       err     [2];

    bus_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst_n(rst_n[0]), .ce(ce[0]), .wr(wr[0]), .rd(rd[0]),
        .addr(addr[0]), .data_wr(data_wr[0]), .data_rd(data_rd[0]),
        .ack(ack[0]), .err(err[0])
    );

    bus_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(3)) u_slow (
        .clk(clk), .rst_n(rst_n[1]), .ce(ce[1]), .wr(wr[1]), .rd(rd[1]),
        .addr(addr[1]), .data_wr(data_wr[1]), .data_rd(data_rd[1]),
        .ack(ack[1]), .err(err[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain storage per unit plus the held read value and lock bit.
    logic [7:0] mem_m [2][256];
    logic [7:0] drd_m [2];
    bit         lock_m[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int waits_of(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    function automatic int depth_of(input int u);
        return (u == 0) ? 256 : 128;
    endfunction

    task automatic model_reset(input int u);
        for (int i = 0; i < 256; i++)
            mem_m[u][i] = 8'h00;
        drd_m[u]  = 8'h00;
        lock_m[u] = 1'b0;
    endtask

    task automatic txn(input int u, input bit w, input bit r, input int a, input int d);
        int  nw;
        int  dep;
        bit  e;
        nw  = waits_of(u);
        dep = depth_of(u);

        e = (w && r) || (a >= dep);
`ifdef BUS_RESPONDER_WPROT_EN
        if (w && !r && lock_m[u] && (a < dep / 2))
            e = 1'b1;
`endif
        if (a >= dep)
            drd_m[u] = 8'h00;
        else if (r && !w)
            drd_m[u] = mem_m[u][a];
        if (w && !r && !e) begin
            mem_m[u][a] = 8'(d);
            if (a == dep - 1)
                lock_m[u] = d[0];
        end

        @(negedge clk);
        ce[u] = 1'b1; wr[u] = w; rd[u] = r;
        addr[u] = 8'(a); data_wr[u] = 8'(d);
        for (int j = 1; j <= nw + 1; j++) begin
            @(negedge clk);
            check($sformatf("u%0d a=%0h early_ack j=%0d", u, a, j), 32'(ack[u]), 32'd0);
            ce[u] = 1'($urandom % 2); wr[u] = 1'($urandom % 2); rd[u] = 1'($urandom % 2);
            addr[u] = 8'($urandom); data_wr[u] = 8'($urandom);
        end
        @(negedge clk);
        ce[u] = 1'b0;
        check($sformatf("u%0d a=%0h ack", u, a), 32'(ack[u]), 32'd1);
        check($sformatf("u%0d a=%0h err", u, a), 32'(err[u]), 32'(e));
        check($sformatf("u%0d a=%0h data_rd", u, a), 32'(data_rd[u]), 32'(drd_m[u]));
        @(negedge clk);
        check($sformatf("u%0d a=%0h ack_fall", u, a), 32'(ack[u]), 32'd0);
        check($sformatf("u%0d a=%0h data_rd_held", u, a), 32'(data_rd[u]), 32'(drd_m[u]));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; ce[u] = 1'b0; wr[u] = 1'b0; rd[u] = 1'b0;
            addr[u] = 8'h00; data_wr[u] = 8'h00;
            model_reset(u);
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset ack", u), 32'(ack[u]), 32'd0);
            check($sformatf("u%0d reset err", u), 32'(err[u]), 32'd0);
            check($sformatf("u%0d reset data_rd", u), 32'(data_rd[u]), 32'd0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        txn(0, 1, 0, 'h55, 'hF0);
        txn(0, 1, 0, 'hAA, 'h0F);
        txn(0, 1, 0, 'hBB, 'hCC);
        txn(0, 0, 1, 'h55, 0);
        txn(0, 0, 1, 'hAA, 0);
        txn(0, 0, 1, 'hBB, 0);

        // ce held with no strobe is not a request.
        @(negedge clk);
        ce[0] = 1'b1; wr[0] = 1'b0; rd[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("u0 no_strobe ack j=%0d", j), 32'(ack[0]), 32'd0);
        end
        ce[0] = 1'b0;

        txn(0, 1, 1, 'h20, 'h3C);
        txn(0, 0, 1, 'h20, 0);

        txn(1, 1, 0, 'h10, 'h5A);
        txn(1, 0, 1, 'h10, 0);
        txn(1, 1, 0, 'h00, 'h42);
        txn(1, 0, 1, 'h80, 0);
        txn(1, 1, 0, 'h80, 'h11);
        txn(1, 0, 1, 'h00, 0);

`ifdef BUS_RESPONDER_WPROT_EN
        txn(0, 1, 0, 'hFF, 'h01);
        txn(0, 1, 0, 'h05, 'h99);
        txn(0, 0, 1, 'h05, 0);
        txn(0, 0, 1, 'hFF, 0);
        txn(0, 1, 0, 'hFF, 'h00);
        txn(0, 1, 0, 'h05, 'h99);
        txn(0, 0, 1, 'h05, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            int u;
            int op;
            int a;
            u  = int'($urandom % 2);
            op = int'($urandom % 8);
            case ($urandom % 4)
                0: a = int'($urandom % 256);
                1: a = depth_of(u) - 1;
                default: a = int'($urandom_range(0, 7));
            endcase
            txn(u, op < 4 || op == 7, op >= 4, a, int'($urandom % 256));
        end

        // Reset during the wait phase of a write drops it without ack.
        txn(1, 1, 0, 'h10, 'hA5);
        @(negedge clk);
        ce[1] = 1'b1; wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 8'h30; data_wr[1] = 8'h77;
        @(negedge clk);
        ce[1] = 1'b0;
        check("u1 rst_wait ack_before", 32'(ack[1]), 32'd0);
        rst_n[1] = 1'b0;
        model_reset(1);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        check("u1 rst_wait data_rd", 32'(data_rd[1]), 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("u1 rst_wait no_ack j=%0d", j), 32'(ack[1]), 32'd0);
        end
        txn(1, 0, 1, 'h30, 0);
        txn(1, 0, 1, 'h10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
